// File: rtl/inc_sequencer.sv
// inc_sequencer: serialises a multi-target increment mask into one-hot
// INC_sel/INC_en strobes, lowest target index first, then pulses done.
// Target bit order: 0=ROW, 1=COL, 2=CURR, 3=STA, 4=STB, 5=STC, 6=R1.
// Optional build macro INC_SPACING_EN inserts one idle cycle after every strobe.
module inc_sequencer #(
    parameter int N_TGT = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [N_TGT-1:0] req_mask,
    output logic             req_ready,
    input  logic             abort,
    output logic [N_TGT-1:0] INC_sel,
    output logic             INC_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

`ifdef INC_SPACING_EN
    // After a strobe the sequencer parks in the gap state for one cycle.
    localparam state_t ST_AFTER_STROBE = ST_GAP;
`else
    localparam state_t ST_AFTER_STROBE = ST_ISSUE;
`endif

    localparam logic [N_TGT-1:0] ZERO_MASK = {N_TGT{1'b0}};

    // Isolate the lowest set bit of a mask (two's-complement trick).
    function automatic logic [N_TGT-1:0] lowest_bit(input logic [N_TGT-1:0] m);
        lowest_bit = m & (~m + N_TGT'(1));
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [N_TGT-1:0] pending_r;
    logic [N_TGT-1:0] pending_s;
    logic [N_TGT-1:0] sel_r;
    logic [N_TGT-1:0] sel_s;
    logic             en_r;
    logic             en_s;
    logic             done_r;
    logic             done_s;
    logic             busy_r;
    logic             busy_s;

    assign req_ready = (state_r == ST_IDLE);
    assign INC_sel   = sel_r;
    assign INC_en    = en_r;
    assign done      = done_r;
    assign busy      = busy_r;

    // Next-state and next-output logic; every output defaults to idle.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        sel_s     = ZERO_MASK;
        en_s      = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_mask != ZERO_MASK) begin
                        sel_s     = lowest_bit(req_mask);
                        en_s      = 1'b1;
                        pending_s = req_mask & ~lowest_bit(req_mask);
                        state_s   = ST_AFTER_STROBE;
                    end else begin
                        done_s    = 1'b1;
                        pending_s = ZERO_MASK;
                        state_s   = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    pending_s = ZERO_MASK;
                    state_s   = ST_IDLE;
                end else if (pending_r != ZERO_MASK) begin
                    sel_s     = lowest_bit(pending_r);
                    en_s      = 1'b1;
                    pending_s = pending_r & ~lowest_bit(pending_r);
                    state_s   = ST_AFTER_STROBE;
                end else begin
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end
            end
`ifdef INC_SPACING_EN
            ST_GAP: begin
                if (abort) begin
                    pending_s = ZERO_MASK;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
`endif
            ST_DONE: begin
                pending_s = ZERO_MASK;
                state_s   = ST_IDLE;
            end
            default: begin
                pending_s = ZERO_MASK;
                state_s   = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, pending mask and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            pending_r <= ZERO_MASK;
            sel_r     <= ZERO_MASK;
            en_r      <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            sel_r     <= sel_s;
            en_r      <= en_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
        end
    end

endmodule
